// File: rtl/rpl_age_arbiter_if.sv
// Request/grant bundle between the SIC array (master) and the age arbiter (slave).
interface rpl_age_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ID_WIDTH-1:0] req_id;
    logic [ID_WIDTH-1:0]         base_id;
    logic                        flush;
    logic [NUM_REQ-1:0]          grant;
    logic                        grant_valid;
    logic [IDX_W-1:0]            grant_idx;
    logic                        hold_timeout;

    modport master (
        output req_valid, req_id, base_id, flush,
        input  grant, grant_valid, grant_idx, hold_timeout
    );

    modport slave (
        input  req_valid, req_id, base_id, flush,
        output grant, grant_valid, grant_idx, hold_timeout
    );
endinterface

// File: rtl/rpl_age_arbiter.sv
// Oldest-first arbiter for a shared ALU/memory port with held, registered grants.
// Optional forced release after MAX_HOLD owned cycles: define RPL_ARB_TIMEOUT_EN.
module rpl_age_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 4,
    parameter int MAX_HOLD = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    rpl_age_arbiter_if.slave   arb
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic                 grant_valid_q, grant_valid_d;

    logic [NUM_REQ-1:0]   exclude;
    logic [NUM_REQ-1:0]   cand;
    logic [NUM_REQ-1:0]   evict_mask;
    logic [ID_WIDTH-1:0]  age [NUM_REQ];
    logic [ID_WIDTH-1:0]  best_age;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic                 owner_req;
    logic                 release_own;
    logic                 force_release;

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("rpl_age_arbiter: NUM_REQ must be at least 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("rpl_age_arbiter: MAX_HOLD must be at least 1");
    end

`ifdef RPL_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] evict_q, evict_d;
    logic               timeout_q, timeout_d;

    // The owner is evicted on its MAX_HOLD-th owned cycle, so it holds exactly MAX_HOLD cycles.
    assign force_release = (state_q == OWNED) && owner_req && (hold_cnt_q == HOLD_LAST);
    assign evict_mask    = evict_q;
`else
    assign force_release = 1'b0;
    assign evict_mask    = '0;
`endif

    assign owner_req   = |(grant_q & arb.req_valid);
    assign release_own = (state_q == OWNED) && (!owner_req || force_release);
    assign exclude     = evict_mask | ((state_q == OWNED) ? grant_q : '0);
    assign cand        = arb.req_valid & ~exclude;

    // Ages are taken relative to base_id so the comparison survives ID wrap-around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            age[i] = arb.req_id[i*ID_WIDTH +: ID_WIDTH] - arb.base_id;
            if (cand[i] && (!win_found || (age[i] < best_age))) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                best_age  = age[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        if (arb.flush) begin
            state_d     = IDLE;
            grant_d     = '0;
            grant_idx_d = '0;
        end else if ((state_q == IDLE) || release_own) begin
            if (win_found) begin
                state_d     = OWNED;
                grant_d     = NUM_REQ'(1) << win_idx;
                grant_idx_d = win_idx;
            end else begin
                state_d     = IDLE;
                grant_d     = '0;
                grant_idx_d = '0;
            end
        end
        grant_valid_d = |grant_d;
    end

`ifdef RPL_ARB_TIMEOUT_EN
    always_comb begin
        timeout_d = force_release && !arb.flush;
        evict_d   = timeout_d ? grant_q : '0;
        if ((grant_d != grant_q) || (state_d == IDLE)) begin
            hold_cnt_d = '0;
        end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
`ifdef RPL_ARB_TIMEOUT_EN
            hold_cnt_q    <= '0;
            evict_q       <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
`ifdef RPL_ARB_TIMEOUT_EN
            hold_cnt_q    <= hold_cnt_d;
            evict_q       <= evict_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign arb.grant       = grant_q;
    assign arb.grant_valid = grant_valid_q;
    assign arb.grant_idx   = grant_idx_q;
`ifdef RPL_ARB_TIMEOUT_EN
    assign arb.hold_timeout = timeout_q;
`else
    assign arb.hold_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rpl_age_arbiter.sv
// Directed scoreboard bench for rpl_age_arbiter; expected grants are queued with each stimulus step.
module tb_rpl_age_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int ID_WIDTH = 4;
    localparam int MAX_HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [3:0] exp_grant_q[$];
    logic       exp_to_q[$];
    string      exp_tag_q[$];

    rpl_age_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) arb_if ();

    rpl_age_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_WIDTH(ID_WIDTH),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .arb  (arb_if)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pack_ids(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] eg;
        logic       et;
        string      tag;
        if (exp_grant_q.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            eg  = exp_grant_q.pop_front();
            et  = exp_to_q.pop_front();
            tag = exp_tag_q.pop_front();
            compare({tag, ".grant"},        {4'b0, arb_if.grant},        {4'b0, eg});
            compare({tag, ".grant_valid"},  {7'b0, arb_if.grant_valid},  {7'b0, |eg});
            compare({tag, ".grant_idx"},    {6'b0, arb_if.grant_idx},    {6'b0, idx_of(eg)});
            compare({tag, ".hold_timeout"}, {7'b0, arb_if.hold_timeout}, {7'b0, et});
        end
    endtask

    task automatic applyStimulus(input logic [3:0] rv, input logic [15:0] ids, input logic [3:0] base,
                                 input logic fl, input logic [3:0] eg, input logic et, input string tag);
        arb_if.req_valid = rv;
        arb_if.req_id    = ids;
        arb_if.base_id   = base;
        arb_if.flush     = fl;
        exp_grant_q.push_back(eg);
        exp_to_q.push_back(et);
        exp_tag_q.push_back(tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [15:0] ids;
        arb_if.req_valid = '0;
        arb_if.req_id    = '0;
        arb_if.base_id   = '0;
        arb_if.flush     = 1'b0;

        #12;
        compare("reset.grant",        {4'b0, arb_if.grant},        8'd0);
        compare("reset.grant_valid",  {7'b0, arb_if.grant_valid},  8'd0);
        compare("reset.grant_idx",    {6'b0, arb_if.grant_idx},    8'd0);
        compare("reset.hold_timeout", {7'b0, arb_if.hold_timeout}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single request");
        ids = pack_ids(0, 3, 0, 0);
        applyStimulus(4'b0010, ids, 4'd0, 1'b0, 4'b0010, 1'b0, "single.grant");
        applyStimulus(4'b0000, ids, 4'd0, 1'b0, 4'b0000, 1'b0, "single.release");

        $display("[TB] age ordering with wrap");
        ids = pack_ids(15, 1, 14, 2);
        applyStimulus(4'b1111, ids, 4'd14, 1'b0, 4'b0100, 1'b0, "wrap.first");
        applyStimulus(4'b1111, ids, 4'd14, 1'b0, 4'b0100, 1'b0, "wrap.hold");
        applyStimulus(4'b1011, ids, 4'd14, 1'b0, 4'b0001, 1'b0, "wrap.second");
        applyStimulus(4'b1010, ids, 4'd14, 1'b0, 4'b0010, 1'b0, "wrap.third");
        applyStimulus(4'b1000, ids, 4'd14, 1'b0, 4'b1000, 1'b0, "wrap.fourth");
        applyStimulus(4'b0000, ids, 4'd14, 1'b0, 4'b0000, 1'b0, "wrap.idle");

        $display("[TB] no preemption");
        ids = pack_ids(2, 0, 0, 5);
        applyStimulus(4'b1000, ids, 4'd0, 1'b0, 4'b1000, 1'b0, "nopre.own");
        applyStimulus(4'b1001, ids, 4'd0, 1'b0, 4'b1000, 1'b0, "nopre.hold1");
        applyStimulus(4'b1001, ids, 4'd0, 1'b0, 4'b1000, 1'b0, "nopre.hold2");
        applyStimulus(4'b0001, ids, 4'd0, 1'b0, 4'b0001, 1'b0, "nopre.handoff");
        applyStimulus(4'b0000, ids, 4'd0, 1'b0, 4'b0000, 1'b0, "nopre.idle");

        $display("[TB] tie, base change and flush");
        ids = pack_ids(0, 7, 7, 0);
        applyStimulus(4'b0110, ids, 4'd0, 1'b0, 4'b0010, 1'b0, "tie.low_index");
        applyStimulus(4'b0110, ids, 4'd8, 1'b0, 4'b0010, 1'b0, "tie.base_change_hold");
        applyStimulus(4'b0110, ids, 4'd0, 1'b1, 4'b0000, 1'b0, "flush.drop");
        applyStimulus(4'b0110, ids, 4'd0, 1'b0, 4'b0010, 1'b0, "flush.regrant");
        applyStimulus(4'b0000, ids, 4'd0, 1'b0, 4'b0000, 1'b0, "flush.idle");

        $display("[TB] long hold");
        ids = pack_ids(0, 1, 0, 0);
        applyStimulus(4'b0011, ids, 4'd0, 1'b0, 4'b0001, 1'b0, "hold.grant");
`ifdef RPL_ARB_TIMEOUT_EN
        for (int k = 0; k < MAX_HOLD - 1; k++) begin
            applyStimulus(4'b0011, ids, 4'd0, 1'b0, 4'b0001, 1'b0, "hold.owned");
        end
        applyStimulus(4'b0011, ids, 4'd0, 1'b0, 4'b0010, 1'b1, "hold.timeout");
        applyStimulus(4'b0011, ids, 4'd0, 1'b0, 4'b0010, 1'b0, "hold.after");
`else
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0011, ids, 4'd0, 1'b0, 4'b0001, 1'b0, "hold.unlimited");
        end
`endif
        applyStimulus(4'b0000, ids, 4'd0, 1'b0, 4'b0000, 1'b0, "hold.idle");

        $display("[TB] async reset mid-ownership");
        ids = pack_ids(0, 0, 9, 0);
        applyStimulus(4'b0100, ids, 4'd0, 1'b0, 4'b0100, 1'b0, "areset.own");
        #1;
        rst_n = 1'b0;
        arb_if.req_valid = '0;
        #1;
        compare("areset.grant",       {4'b0, arb_if.grant},       8'd0);
        compare("areset.grant_valid", {7'b0, arb_if.grant_valid}, 8'd0);
        compare("areset.grant_idx",   {6'b0, arb_if.grant_idx},   8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0000, ids, 4'd0, 1'b0, 4'b0000, 1'b0, "areset.idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rpl_age_arbiter.md
Name: rpl_age_arbiter

Overview:
- Shares one execution resource (ALU port or memory port) among NUM_REQ single-instruction controllers.
- Each controller presents a request valid plus its issue ID.
- The oldest in-flight instruction wins, computed relative to a moving base ID, so ID wrap-around is handled.
- The grant is registered and held while the owner keeps requesting, which supports multi-cycle accesses. Sits between the SIC array and the shared ALU/memory.

Parameters:
- NUM_REQ, 4, number of requesting SICs (>=2).
- ID_WIDTH, 4, issue ID width; IDs compare modulo 2^ID_WIDTH.
- MAX_HOLD, 64, hold-cycle limit (used only with the optional feature).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-SIC request.
- req_id  input  NUM_REQ*ID_WIDTH  per-SIC issue ID; slice i is bits [i*ID_WIDTH +: ID_WIDTH].
- base_id  input  ID_WIDTH  issue ID of the oldest uncommitted instruction.
- flush  input  1  pipeline flush; drops the current owner.
- grant  output  NUM_REQ  one-hot grant, registered.
- grant_valid  output  1  OR of grant.
- grant_idx  output  $clog2(NUM_REQ)  index of the owner; 0 when none.
- hold_timeout  output  1  one-cycle pulse when a forced release occurs (optional feature only; constant 0 otherwise).

Behaviour:
- Reset: grant=0, grant_valid=0, grant_idx=0, hold_timeout=0, state=IDLE, hold counter=0.
- Age: age_i = (req_id_i - base_id) mod 2^ID_WIDTH, unsigned ID_WIDTH-bit subtraction.
  - Winner = valid requester with the smallest age.
  - Equal age: lowest index wins.
- Candidate set: valid requesters, excluding the current owner when that owner is releasing.
- State machine, two states:
  - IDLE: if any req_valid and !flush, register grant to the winner next cycle and go to OWNED. Otherwise stay in IDLE.
  - OWNED:
    - Owner's req_valid still high and !flush: hold the grant unchanged. Younger or older newcomers do NOT preempt.
    - Owner's req_valid drops: release. In the same cycle, arbitrate among the remaining requesters. If one exists, grant it next cycle (zero-bubble handoff, stay OWNED); else go to IDLE with grant=0.
  - flush (either state, highest priority): grant=0 next cycle, state=IDLE, counter=0. Requests present during the flush cycle are ignored; arbitration resumes the following cycle.
- Latency: request to grant is exactly 1 cycle when the resource is free.
- Release latency: owner drops req_valid in cycle t, grant clears or moves at edge t+1.
- A granted SIC sees grant while it keeps req_valid asserted. Deasserting req_valid for one cycle ends the tenure.
- Simultaneous owner release and new request from the same index: treated as a new request, but that index is excluded in the release cycle. It can win again at the next arbitration.
- base_id may change at any cycle and affects the next arbitration only, never the current owner.
- Reset mid-ownership: asynchronous, with immediate return to reset values.
- No combinational path from req_valid to grant.

Optional Feature:
- Macro RPL_ARB_TIMEOUT_EN.
- When defined:
  - A hold counter, $clog2(MAX_HOLD+1) bits, increments every OWNED cycle and clears on any grant change.
  - When it reaches MAX_HOLD with the owner still requesting, the owner is force-released as if it had dropped req_valid. The next oldest other requester is granted, or the block goes to IDLE.
  - hold_timeout pulses for 1 cycle.
  - The evicted index is masked out of arbitration for one cycle.
- When undefined: no counter, hold_timeout tied 0, ownership is unlimited.

Test Plan:
1. Single request: base_id=0, req_valid=4'b0010, id1=3, rising edge -> grant=4'b0010 one cycle later, grant_idx=1. Drop req -> grant=0 next cycle.
2. Age ordering with wrap: base_id=14, ids {15,1,14,2}, all valid -> grant index 2 (age 0). After its release -> index 0 (age 1), then 1, then 3, each handoff zero-bubble.
3. No preemption: index 3 owns with id 5; index 0 requests with id 2 (older), base_id=0 -> grant stays 4'b1000 until index 3 drops, then 4'b0001 next cycle.
4. Tie and flush: ids equal (7) on indices 1 and 2 -> index 1 wins. flush during ownership -> grant=0 next cycle, state IDLE, re-grant to index 1 one cycle after flush deasserts.
5. Timeout (RPL_ARB_TIMEOUT_EN, MAX_HOLD=4): index 0 holds while index 1 waits -> after 4 owned cycles hold_timeout=1 for one cycle, grant moves to 4'b0010. Macro undefined -> index 0 keeps the grant indefinitely.
6. Async reset asserted mid-ownership -> grant, grant_valid and grant_idx go to 0 immediately, without a clock edge.
